// File: rtl/prog_loader.sv
// prog_loader
//   Byte-stream program loader. Receives a framed image
//   (SYNC_BYTE, LEN, LEN data bytes[, CSUM]) and writes the data bytes into
//   the instruction memory. The CPU is held in reset (cpu_hold=1) until a
//   complete, verified image has been stored.
//
//   Optional feature: define LOADER_CHECKSUM_EN to require a trailing CSUM
//   byte such that (LEN + sum(data) + CSUM) mod 256 == 0. When the macro is
//   undefined there is no CSUM byte and no checksum logic.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   in_data    in   incoming byte
//   in_valid   in   in_data is valid
//   in_ready   out  loader can accept a byte (combinational from state/reset)
//   mem_we     out  instruction-memory write strobe, one cycle per byte
//   mem_addr   out  write address
//   mem_wdata  out  write data
//   cpu_hold   out  drives cpu_top.reset; 1 holds the CPU
//   done       out  image loaded; sticky until reset
//   err        out  last frame failed; sticky until the next accepted sync
//   err_code   out  1 = checksum, 2 = timeout, 3 = zero length, 0 when no err
module prog_loader #(
  parameter int          ADDR_W    = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int          TIMEOUT   = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ERR_CSUM = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
  localparam logic [1:0] ERR_LEN0 = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;       // next write address
  logic [7:0]          rem_q, rem_d;       // data bytes still expected
  logic [TMO_W-1:0]    tmo_q, tmo_d;       // idle cycles inside a frame
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic                err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          sum_q, sum_d;       // running LEN + data sum, mod 256
  logic [7:0]          sum_next;
`endif

  logic xfer;

  assign in_ready  = !reset && (state_q != S_DONE);
  assign xfer      = in_valid && in_ready;

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = (state_q == S_DONE);
  assign cpu_hold  = !done;
  assign err       = err_q;
  assign err_code  = err_code_q;

`ifdef LOADER_CHECKSUM_EN
  assign sum_next = sum_q + in_data;
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    tmo_d       = tmo_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (xfer && (in_data == SYNC_BYTE)) begin
          state_d    = S_LEN;
          err_d      = 1'b0;
          err_code_d = 2'd0;
`ifdef LOADER_CHECKSUM_EN
          sum_d      = 8'd0;
`endif
        end
      end

      S_LEN, S_DATA, S_CSUM: begin
        if (xfer) begin
          // A transfer always wins over a timeout in the same cycle.
          tmo_d = '0;
          unique case (state_q)
            S_LEN: begin
              rem_d = in_data;
              cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
              sum_d = sum_next;
`endif
              if (in_data == 8'd0) begin
                state_d    = S_IDLE;
                err_d      = 1'b1;
                err_code_d = ERR_LEN0;
              end else begin
                state_d = S_DATA;
              end
            end
            S_DATA: begin
              mem_we_d    = 1'b1;
              mem_addr_d  = cnt_q;
              mem_wdata_d = in_data;
              cnt_d       = cnt_q + 1'b1;
              rem_d       = rem_q - 8'd1;
`ifdef LOADER_CHECKSUM_EN
              sum_d       = sum_next;
              if (rem_q == 8'd1) state_d = S_CSUM;
`else
              if (rem_q == 8'd1) state_d = S_DONE;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
              if (sum_next == 8'd0) begin
                state_d = S_DONE;
              end else begin
                state_d    = S_IDLE;
                err_d      = 1'b1;
                err_code_d = ERR_CSUM;
              end
            end
`endif
            default: ;
          endcase
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          // This idle edge is the TIMEOUT-th one in a row.
          state_d    = S_IDLE;
          tmo_d      = '0;
          err_d      = 1'b1;
          err_code_d = ERR_TMO;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_DONE: ;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: all state, including the counters and the output registers, is
    // reset so that an abandoned frame leaves nothing behind.
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= 8'd0;
      tmo_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
      err_q       <= 1'b0;
      err_code_q  <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= 8'd0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      tmo_q       <= tmo_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

endmodule
